// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: the opcodes the back end decodes, the special
// register indices, and the captured write-back stage record.
package mips_pkg;

  localparam logic [5:0] OP_JAL = 6'h03;
  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam logic [4:0] REG_LINK = 5'd31;

  typedef struct packed {
    logic        valid;
    logic        reg_write;
    logic [5:0]  opcode;
    logic [4:0]  rd;
    logic [31:0] alu_result;
    logic [31:0] mem_data;
    logic [31:0] pc;
  } wb_entry_t;

  function automatic logic is_load(input logic [5:0] op);
    return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
           (op == OP_LBU) || (op == OP_LHU);
  endfunction

endpackage

// File: rtl/wb_stage_load_extract.sv
// Big-endian load data extraction and extension (byte 0 = bits 31:24), plus the
// alignment check for half-word and word loads.
module load_extract
  import mips_pkg::*;
(
  input  logic [5:0]  opcode,
  input  logic [1:0]  off,
  input  logic [31:0] mem_data,
  output logic [31:0] value,
  output logic        misaligned
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    byte_v = mem_data[31:24];
    case (off)
      2'd1:    byte_v = mem_data[23:16];
      2'd2:    byte_v = mem_data[15:8];
      2'd3:    byte_v = mem_data[7:0];
      default: byte_v = mem_data[31:24];
    endcase
    half_v = off[1] ? mem_data[15:0] : mem_data[31:16];
  end

  always_comb begin
    value      = mem_data;
    misaligned = 1'b0;
    case (opcode)
      OP_LB:  value = {{24{byte_v[7]}}, byte_v};
      OP_LBU: value = {24'd0, byte_v};
      OP_LH: begin
        value      = {{16{half_v[15]}}, half_v};
        misaligned = off[0];
      end
      OP_LHU: begin
        value      = {16'd0, half_v};
        misaligned = off[0];
      end
      OP_LW: begin
        value      = mem_data;
        misaligned = (off != 2'd0);
      end
      default: value = mem_data;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// MIPS write-back stage: captures the MEM result, drives the register-file write
// port and a forwarding view. Optional retire counter under WB_RETIRE_COUNT_EN.
module wb_stage
  import mips_pkg::*;
#(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned LINK_REG = 31
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [5:0]        opcode,
  input  logic [4:0]        rd,
  input  logic              register_write,
  input  logic              valid,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] mem_data,
  input  logic [DATA_W-1:0] pc,
  input  logic              stall,
  output logic              wr_en,
  output logic [4:0]        wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              fwd_valid,
  output logic [4:0]        fwd_addr,
  output logic [DATA_W-1:0] fwd_data,
  output logic              misalign_err
`ifdef WB_RETIRE_COUNT_EN
  ,
  output logic [31:0]       retired_count
`endif
);

  localparam logic [4:0] LINK_IDX = 5'(LINK_REG);

  wb_entry_t   stage_q;
  logic        fresh_q;
  logic [31:0] load_value;
  logic        misaligned;
  logic [4:0]  eff_rd;
  logic [31:0] result;
  logic        writes_reg;

  load_extract u_load_extract (
    .opcode     (stage_q.opcode),
    .off        (stage_q.alu_result[1:0]),
    .mem_data   (stage_q.mem_data),
    .value      (load_value),
    .misaligned (misaligned)
  );

  always_comb begin
    eff_rd = (stage_q.opcode == OP_JAL) ? LINK_IDX : stage_q.rd;
    if (is_load(stage_q.opcode))
      result = load_value;
    else if (stage_q.opcode == OP_JAL)
      result = stage_q.pc + 32'd8;
    else
      result = stage_q.alu_result;
    writes_reg = stage_q.valid && stage_q.reg_write && (eff_rd != REG_ZERO) && !misaligned;
  end

  assign fwd_valid = writes_reg;
  assign fwd_addr  = eff_rd;
  assign fwd_data  = result;

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stage_q <= '0;
      fresh_q <= 1'b0;
    end else if (!stall) begin
      stage_q <= '{valid: valid, reg_write: register_write, opcode: opcode, rd: rd,
                   alu_result: alu_result, mem_data: mem_data, pc: pc};
      fresh_q <= valid;
    end else begin
      fresh_q <= 1'b0;
    end
  end

  // Fresh gates the write so a held instruction writes exactly once.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_en        <= 1'b0;
      wr_addr      <= '0;
      wr_data      <= '0;
      misalign_err <= 1'b0;
    end else begin
      wr_en        <= fresh_q && writes_reg;
      wr_addr      <= eff_rd;
      wr_data      <= result;
      misalign_err <= fresh_q && stage_q.valid && misaligned;
    end
  end

`ifdef WB_RETIRE_COUNT_EN
  always_ff @(posedge clk) begin
    if (!reset_n)
      retired_count <= '0;
    else if (fresh_q && stage_q.valid && !misaligned && (writes_reg || !stage_q.reg_write))
      retired_count <= retired_count + 32'd1;
  end
`endif

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Write-back stage of the MIPS pipeline; it is the writing counterpart of the RD register-read stage.
- Captures the MEM-stage result, extracts and extends load data, and drives the single register-file write port that RD's register_1/register_2 read ports observe.
- Provides a forwarding view of the in-flight write and flags misaligned loads.

Parameters:
- DATA_W, 32, datapath width; only 32 is supported.
- LINK_REG, 31, destination register index forced for jal.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- opcode  in  6  MEM-stage opcode.
- rd  in  5  destination register index.
- register_write  in  1  instruction writes a register.
- valid  in  1  MEM stage holds a real instruction (0 = bubble).
- alu_result  in  32  ALU result; also the load address.
- mem_data  in  32  aligned data word read from memory.
- pc  in  32  instruction PC, used for the jal link value.
- stall  in  1  hold stage contents; accept no new input.
- wr_en  out  1  register-file write enable.
- wr_addr  out  5  register-file write index.
- wr_data  out  32  register-file write data.
- fwd_valid  out  1  stage holds a pending nonzero-register write.
- fwd_addr  out  5  forwarded register index.
- fwd_data  out  32  forwarded value.
- misalign_err  out  1  one-cycle pulse on a misaligned load.

Behaviour:
- Reset (reset_n=0 at a clock edge): all stage registers and all outputs go to 0; the fresh flag clears.
  - Reset dominates stall and valid.
  - Reset arriving mid-hold discards the held instruction with no write.
- Capture: on an edge with stall=0, latch opcode, rd, register_write, alu_result, mem_data, pc and valid; set fresh=valid.
  - On an edge with stall=1, all captured fields hold and fresh clears.
- Latency: wr_en and wr_data are registered and appear 1 cycle after capture.
  - wr_en=1 for exactly one cycle per instruction, including when a stall follows the capture.
- Write conditions: wr_en=1 when fresh, register_write=1, effective rd≠0 and no misalignment. Writes to r0 are always suppressed.
- Result select by opcode (MIPS big-endian; byte 0 = bits 31:24; off = alu_result[1:0]):
  - lb 0x20: byte at off, sign-extended. lbu 0x24: same byte, zero-extended.
  - lh 0x21: half at off[1] (0 → bits 31:16), sign-extended. lhu 0x25: same half, zero-extended.
  - lw 0x23: mem_data.
  - jal 0x03: pc+8; effective rd=LINK_REG regardless of the rd input.
  - Any other opcode: alu_result.
- Misalignment:
  - Condition: lh/lhu with off[0]=1, or lw with off≠0.
  - Effect: suppress the write and pulse misalign_err in the same cycle the write would have occurred.
  - Byte loads never misalign.
- Forwarding (combinational from stage registers):
  - fwd_valid = captured valid & register_write & effective rd≠0 & not misaligned.
  - fwd_valid stays asserted while stalled.
  - fwd_data equals the value wr_data carries or carried for that instruction.
- Bubbles: valid=0 → no write, no error, fwd_valid=0.
- Back-to-back capture: two consecutive unstalled captures produce two consecutive write cycles with no gap.

Optional Feature:
- Macro: WB_RETIRE_COUNT_EN.
- When defined:
  - Adds output retired_count (32 bits), reset to 0.
  - Increments by 1 in each cycle wr_en=1, and also for fresh valid instructions with register_write=0 that are not misaligned.
  - Wraps from 0xFFFFFFFF to 0.
- When undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package mips_pkg holds:
  - Opcode constants OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_JAL.
  - REG_ZERO and REG_LINK.
  - These are reused by RD and the decoder.
- One natural sub-module, load_extract: purely combinational; inputs opcode, off, mem_data; outputs the extended value and a misaligned flag.

Test Plan:
- lb, alu_result=0x1001, mem_data=0x80FF7F01, rd=5 → next cycle wr_en=1, wr_addr=5, wr_data=0xFFFFFFFF; repeat with lbu → wr_data=0x000000FF.
- lh, alu_result=0x1002, mem_data=0x12348001, rd=7 → wr_data=0xFFFF8001; same op with alu_result=0x1003 → wr_en=0, misalign_err=1 for one cycle.
- jal, pc=0x00400010, rd=0 → wr_addr=31, wr_data=0x00400018.
- Arithmetic op, register_write=1, rd=0, alu_result=0xDEADBEEF → wr_en=0, fwd_valid=0.
- Capture an add to rd=9, then assert stall for 3 cycles → exactly one wr_en pulse; fwd_valid=1, fwd_addr=9 throughout the stall.
- Pull reset_n low during that stall → all outputs 0 on the next edge; no write after release. With WB_RETIRE_COUNT_EN defined: 3 retiring ops → retired_count=3; preloaded 0xFFFFFFFF plus 1 op → 0.
